// File: rtl/sram_2p_march_bist_ctrl.sv
// sram_2p_march_bist_ctrl: March C- BIST engine for one side of an RM_IHPSG13_2P bm_bist macro.
// Define SRAM_BIST_CHKBRD_EN for a second checkerboard-background pass and the FAIL_PASS output.
module sram_2p_march_bist_ctrl #(
  parameter int P_ADDR_WIDTH = 9,
  parameter int P_DATA_WIDTH = 16,
  parameter int P_READ_LAT = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]              FAIL_ELEM,
`ifdef SRAM_BIST_CHKBRD_EN
  output logic                    FAIL_PASS,
`endif
  output logic                    BIST_EN,
  output logic                    BIST_MEN,
  output logic                    BIST_WEN,
  output logic                    BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] BIST_DOUT
);
  localparam int DRW = $clog2(P_READ_LAT + 1);
`ifdef SRAM_BIST_CHKBRD_EN
  localparam int TW = 4;
`else
  localparam int TW = 3;
`endif
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t                  state_q, state_n;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [2:0]              elem_q, elem_n;
  logic                    phase_q, phase_n;
  logic [DRW-1:0]          drain_q;
  logic                    start_ok, run, down, is_read, inv, op_last, elem_last, run_last, drain_done;
  logic [P_DATA_WIDTH-1:0] bg, data;
  logic [TW-1:0]           tag, fail_tag_q;
  logic                    fail_q;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q;
  logic [P_READ_LAT-1:0]   pv;
  logic [P_DATA_WIDTH-1:0] pe [P_READ_LAT];
  logic [P_ADDR_WIDTH-1:0] pa [P_READ_LAT];
  logic [TW-1:0]           pt [P_READ_LAT];
`ifdef SRAM_BIST_CHKBRD_EN
  logic pass_q, pass_n;
  function automatic logic [P_DATA_WIDTH-1:0] chk_pat();
    logic [P_DATA_WIDTH-1:0] p;
    for (int i = 0; i < P_DATA_WIDTH; i++) p[i] = (i % 2) == 0;
    return p;
  endfunction
  assign bg = pass_q ? chk_pat() ^ {P_DATA_WIDTH{addr_q[0]}} : '0;
  assign tag = {pass_q, elem_q};
  assign run_last = elem_last && elem_q == 3'd5 && pass_q;
  assign {FAIL_PASS, FAIL_ELEM} = fail_tag_q;
`else
  assign bg = '0;
  assign tag = elem_q;
  assign run_last = elem_last && elem_q == 3'd5;
  assign FAIL_ELEM = fail_tag_q;
`endif
  assign start_ok = START && (state_q == S_IDLE || state_q == S_DONE);
  assign run = state_q == S_RUN;
  assign down = elem_q == 3'd3 || elem_q == 3'd4;
  assign is_read = elem_q != 3'd0 && !phase_q;
  // Reads of E2/E4 expect ~D; writes of E1/E3 store ~D.
  assign inv = is_read ? (elem_q == 3'd2 || elem_q == 3'd4) : (elem_q == 3'd1 || elem_q == 3'd3);
  assign data = bg ^ {P_DATA_WIDTH{inv}};
  assign op_last = elem_q == 3'd0 || elem_q == 3'd5 || phase_q;
  assign elem_last = op_last && (down ? addr_q == '0 : &addr_q);
  assign drain_done = drain_q == DRW'(P_READ_LAT - 1);
  always_comb begin
    state_n = state_q;
    addr_n = addr_q;
    elem_n = elem_q;
    phase_n = 1'b0;
`ifdef SRAM_BIST_CHKBRD_EN
    pass_n = pass_q;
`endif
    if (start_ok) begin
      state_n = S_RUN;
      addr_n = '0;
      elem_n = '0;
`ifdef SRAM_BIST_CHKBRD_EN
      pass_n = 1'b0;
`endif
    end else if (run) begin
      phase_n = !op_last;
      if (run_last) state_n = S_DRAIN;
      else if (elem_last) begin
        elem_n = elem_q == 3'd5 ? 3'd0 : elem_q + 3'd1;
        addr_n = (elem_q == 3'd2 || elem_q == 3'd3) ? '1 : '0;
`ifdef SRAM_BIST_CHKBRD_EN
        pass_n = pass_q | (elem_q == 3'd5);
`endif
      end else if (op_last) addr_n = down ? addr_q - P_ADDR_WIDTH'(1) : addr_q + P_ADDR_WIDTH'(1);
    end else if (state_q == S_DRAIN && drain_done) state_n = S_DONE;
  end
  always_comb begin
    BIST_EN = run || state_q == S_DRAIN;
    BIST_MEN = run;
    BIST_WEN = run && !is_read;
    BIST_REN = run && is_read;
    BIST_ADDR = run ? addr_q : '0;
    BIST_DIN = BIST_WEN ? data : '0;
    BIST_BM = {P_DATA_WIDTH{BIST_EN}};
    BUSY = BIST_EN;
    DONE = state_q == S_DONE;
    FAIL = fail_q;
    FAIL_ADDR = fail_addr_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      elem_q <= '0;
      phase_q <= 1'b0;
      drain_q <= '0;
      pv <= '0;
      fail_q <= 1'b0;
      fail_addr_q <= '0;
      fail_tag_q <= '0;
`ifdef SRAM_BIST_CHKBRD_EN
      pass_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      addr_q <= addr_n;
      elem_q <= elem_n;
      phase_q <= phase_n;
`ifdef SRAM_BIST_CHKBRD_EN
      pass_q <= pass_n;
`endif
      drain_q <= state_q == S_DRAIN ? drain_q + DRW'(1) : '0;
      for (int i = P_READ_LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pa[i] <= pa[i-1];
        pt[i] <= pt[i-1];
      end
      pv[0] <= BIST_REN;
      pe[0] <= data;
      pa[0] <= addr_q;
      pt[0] <= tag;
      if (start_ok) begin
        fail_q <= 1'b0;
        fail_addr_q <= '0;
        fail_tag_q <= '0;
      end else if (pv[P_READ_LAT-1] && BIST_DOUT != pe[P_READ_LAT-1]) begin
        fail_q <= 1'b1;
        if (!fail_q) begin
          fail_addr_q <= pa[P_READ_LAT-1];
          fail_tag_q <= pt[P_READ_LAT-1];
        end
      end
    end
  end
endmodule
